// File: rtl/if_stage_unit.sv
// Program counter, next-PC select and IF/ID pipeline register.
// Latency: one clock from stall/flush/branch/fetch data to the registered outputs.
// Backpressure: stall holds all state; it overrides flush, which overrides branch.
module if_stage_pc_reg #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] new_pc,
    input  logic [31:0] br_addr,
    input  logic [31:0] fetch_dat,
    output logic [31:0] if_pc,
    output logic [31:0] if_insn,
    output logic        if_en
);

    logic [31:0] pc_nxt;
    logic [31:0] insn_nxt;
    logic        en_nxt;

    // Next IF/ID contents; priority stall > flush > branch > sequential.
    // Redirect targets are taken verbatim, low bits included.
    always_comb begin
        pc_nxt   = if_pc + 32'd4;
        insn_nxt = fetch_dat;
        en_nxt   = 1'b1;
        if (stall) begin
            pc_nxt   = if_pc;
            insn_nxt = if_insn;
            en_nxt   = if_en;
        end else if (flush) begin
            pc_nxt   = new_pc;
            insn_nxt = NOP_INSN;
            en_nxt   = 1'b0;
        end else if (br_taken) begin
            pc_nxt   = br_addr;
        end
    end

    // IF/ID register; asynchronous reset loads the reset vector and a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_pc   <= RESET_VECTOR;
            if_insn <= NOP_INSN;
            if_en   <= 1'b0;
        end else begin
            if_pc   <= pc_nxt;
            if_insn <= insn_nxt;
            if_en   <= en_nxt;
        end
    end

endmodule

// Read-only fetch port into the scratch-pad memory.
// Latency: purely combinational; the word address follows the PC register.
// Backpressure: none; the strobe is permanently asserted and never writes.
module if_stage_fetch (
    input  logic [29:0] word_addr,
    output logic [29:0] spm_addr,
    output logic        spm_as_,
    output logic        spm_rw,
    output logic [31:0] spm_wr_data
);

    localparam logic SPM_READ = 1'b1;

    assign spm_addr    = word_addr;
    assign spm_as_     = 1'b0;
    assign spm_rw      = SPM_READ;
    assign spm_wr_data = 32'h0000_0000;

endmodule

// Instruction-fetch stage: PC, SPM fetch port and IF/ID register.
// Latency: one clock from controls/fetch data to if_pc/if_insn/if_en.
// Backpressure: stall freezes the stage; flush inserts a single bubble.
module if_stage_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] new_pc,
    input  logic [31:0] br_addr,
    output logic [31:0] if_pc,
    output logic [31:0] if_insn,
    output logic        if_en,
    input  logic [31:0] spm_rd_data,
    output logic [29:0] spm_addr,
    output logic        spm_as_,
    output logic        spm_rw,
    output logic [31:0] spm_wr_data
);

    if_stage_pc_reg #(
        .RESET_VECTOR (RESET_VECTOR),
        .NOP_INSN     (NOP_INSN)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .br_taken  (br_taken),
        .new_pc    (new_pc),
        .br_addr   (br_addr),
        .fetch_dat (spm_rd_data),
        .if_pc     (if_pc),
        .if_insn   (if_insn),
        .if_en     (if_en)
    );

    // The PC is the fetch address; only its word bits reach the SPM.
    if_stage_fetch u_fetch (
        .word_addr   (if_pc[31:2]),
        .spm_addr    (spm_addr),
        .spm_as_     (spm_as_),
        .spm_rw      (spm_rw),
        .spm_wr_data (spm_wr_data)
    );

endmodule

// File: tb/tb_if_stage_unit.sv
module tb_if_stage_unit;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, flush, br_taken;
    logic [31:0] new_pc, br_addr;
    logic [31:0] if_pc, if_insn;
    logic        if_en;
    logic [31:0] spm_rd_data;
    logic [29:0] spm_addr;
    logic        spm_as_, spm_rw;
    logic [31:0] spm_wr_data;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        en;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] m_pc, m_insn;
    logic        m_en;
    logic        use_const;
    logic [31:0] const_word;
    int          vectors = 0;
    int          errors  = 0;

    always #5 clk = ~clk;

    // Small SPM model: word content is a fixed scramble of its word address.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a, 2'b11} ^ 32'hA5C3_0F00;
    endfunction

    assign spm_rd_data = use_const ? const_word : mem_word(spm_addr);

    if_stage_unit #(.RESET_VECTOR(RV), .NOP_INSN(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .br_taken(br_taken), .new_pc(new_pc), .br_addr(br_addr),
        .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en),
        .spm_rd_data(spm_rd_data), .spm_addr(spm_addr), .spm_as_(spm_as_),
        .spm_rw(spm_rw), .spm_wr_data(spm_wr_data)
    );

    // Predict the next IF/ID contents from the controls, queue them, clock once.
    task automatic edge_push();
        logic [31:0] rd;
        rd = use_const ? const_word : mem_word(m_pc[31:2]);
        if (stall) begin
        end else if (flush) begin
            m_pc = new_pc; m_insn = NOP; m_en = 1'b0;
        end else if (br_taken) begin
            m_pc = br_addr; m_insn = rd; m_en = 1'b1;
        end else begin
            m_pc = m_pc + 32'd4; m_insn = rd; m_en = 1'b1;
        end
        sb.push_back('{pc: m_pc, insn: m_insn, en: m_en});
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = RV; m_insn = NOP; m_en = 1'b0;
        sb.push_back('{pc: m_pc, insn: m_insn, en: m_en});
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
        new_pc = 32'h0; br_addr = 32'h0;
        use_const = 1'b1; const_word = 32'd128;
        #12;
        model_reset();
        e = sb.pop_front();
        vectors++;
        if (if_pc !== e.pc || if_insn !== e.insn || if_en !== e.en) begin
            errors++;
            $display("FAIL reset_state: got pc=%h insn=%h en=%b want pc=%h insn=%h en=%b",
                     if_pc, if_insn, if_en, e.pc, e.insn, e.en);
        end
        vectors++;
        if (spm_addr !== RV[31:2] || spm_as_ !== 1'b0 || spm_rw !== 1'b1 || spm_wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_spm: got addr=%h as_=%b rw=%b wd=%h want addr=%h as_=0 rw=1 wd=0",
                     spm_addr, spm_as_, spm_rw, spm_wr_data, RV[31:2]);
        end
        @(negedge clk);
        reset = 1'b1;
        edge_push();
        e = sb.pop_front();
        vectors++;
        if (if_pc !== e.pc || if_insn !== e.insn || if_en !== e.en) begin
            errors++;
            $display("FAIL first_fetch: got pc=%h insn=%h en=%b want pc=%h insn=%h en=%b",
                     if_pc, if_insn, if_en, e.pc, e.insn, e.en);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            edge_push();
            e = sb.pop_front();
            vectors++;
            if (if_pc !== e.pc || if_insn !== e.insn || if_en !== e.en) begin
                errors++;
                $display("FAIL seq_fetch[%0d]: got pc=%h insn=%h en=%b want pc=%h insn=%h en=%b",
                         i, if_pc, if_insn, if_en, e.pc, e.insn, e.en);
            end
        end
        vectors++;
        if (if_pc !== 32'h10 || spm_addr !== 30'h4) begin
            errors++;
            $display("FAIL seq_addr: got pc=%h spm_addr=%h want pc=00000010 spm_addr=4", if_pc, spm_addr);
        end
        // Switch to address-dependent memory so fetched data tracks spm_addr.
        use_const = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge_push();
            e = sb.pop_front();
            vectors++;
            if (if_pc !== e.pc || if_insn !== e.insn || if_en !== e.en ||
                spm_addr !== e.pc[31:2] || spm_as_ !== 1'b0 || spm_rw !== 1'b1 || spm_wr_data !== 32'h0) begin
                errors++;
                $display("FAIL mem_fetch[%0d]: got pc=%h insn=%h en=%b addr=%h want pc=%h insn=%h en=%b addr=%h",
                         i, if_pc, if_insn, if_en, spm_addr, e.pc, e.insn, e.en, e.pc[31:2]);
            end
        end
    endtask

    task automatic test_flush_branch();
        flush = 1'b1; new_pc = 32'h154;
        use_const = 1'b1; const_word = 32'd128;
        edge_push();
        e = sb.pop_front();
        vectors++;
        if (if_pc !== e.pc || if_insn !== e.insn || if_en !== e.en) begin
            errors++;
            $display("FAIL flush: got pc=%h insn=%h en=%b want pc=%h insn=%h en=%b",
                     if_pc, if_insn, if_en, e.pc, e.insn, e.en);
        end
        flush = 1'b0; br_taken = 1'b1; br_addr = 32'h100;
        edge_push();
        e = sb.pop_front();
        vectors++;
        if (if_pc !== e.pc || if_insn !== e.insn || if_en !== e.en) begin
            errors++;
            $display("FAIL branch: got pc=%h insn=%h en=%b want pc=%h insn=%h en=%b",
                     if_pc, if_insn, if_en, e.pc, e.insn, e.en);
        end
        // Held branch reloads the same target; unaligned targets kept verbatim.
        use_const = 1'b0; br_addr = 32'h0000_0203;
        for (int i = 0; i < 2; i++) begin
            edge_push();
            e = sb.pop_front();
            vectors++;
            if (if_pc !== e.pc || if_insn !== e.insn || if_en !== e.en || spm_addr !== e.pc[31:2]) begin
                errors++;
                $display("FAIL held_branch[%0d]: got pc=%h insn=%h en=%b addr=%h want pc=%h insn=%h en=%b addr=%h",
                         i, if_pc, if_insn, if_en, spm_addr, e.pc, e.insn, e.en, e.pc[31:2]);
            end
        end
        br_taken = 1'b0;
        edge_push();
        e = sb.pop_front();
        vectors++;
        if (if_pc !== e.pc || if_insn !== e.insn || if_en !== e.en) begin
            errors++;
            $display("FAIL after_branch: got pc=%h insn=%h en=%b want pc=%h insn=%h en=%b",
                     if_pc, if_insn, if_en, e.pc, e.insn, e.en);
        end
    endtask

    task automatic test_stall_priority();
        stall = 1'b1; flush = 1'b1; br_taken = 1'b1;
        new_pc = 32'h0000_0400; br_addr = 32'h0000_0800;
        for (int i = 0; i < 2; i++) begin
            edge_push();
            e = sb.pop_front();
            vectors++;
            if (if_pc !== e.pc || if_insn !== e.insn || if_en !== e.en) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got pc=%h insn=%h en=%b want pc=%h insn=%h en=%b",
                         i, if_pc, if_insn, if_en, e.pc, e.insn, e.en);
            end
        end
        stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            edge_push();
            e = sb.pop_front();
            vectors++;
            if (if_pc !== e.pc || if_insn !== e.insn || if_en !== e.en) begin
                errors++;
                $display("FAIL flush_over_branch[%0d]: got pc=%h insn=%h en=%b want pc=%h insn=%h en=%b",
                         i, if_pc, if_insn, if_en, e.pc, e.insn, e.en);
            end
        end
        flush = 1'b0; br_taken = 1'b0;
        edge_push();
        e = sb.pop_front();
        vectors++;
        if (if_pc !== e.pc || if_insn !== e.insn || if_en !== e.en) begin
            errors++;
            $display("FAIL after_flush: got pc=%h insn=%h en=%b want pc=%h insn=%h en=%b",
                     if_pc, if_insn, if_en, e.pc, e.insn, e.en);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        e = sb.pop_front();
        vectors++;
        if (if_pc !== e.pc || if_insn !== e.insn || if_en !== e.en || spm_addr !== RV[31:2]) begin
            errors++;
            $display("FAIL async_reset: got pc=%h insn=%h en=%b addr=%h want pc=%h insn=%h en=%b addr=%h",
                     if_pc, if_insn, if_en, spm_addr, e.pc, e.insn, e.en, RV[31:2]);
        end
        @(negedge clk);
        reset = 1'b1;
        edge_push();
        e = sb.pop_front();
        vectors++;
        if (if_pc !== e.pc || if_insn !== e.insn || if_en !== e.en) begin
            errors++;
            $display("FAIL post_reset_fetch: got pc=%h insn=%h en=%b want pc=%h insn=%h en=%b",
                     if_pc, if_insn, if_en, e.pc, e.insn, e.en);
        end
    endtask

    task automatic test_wrap();
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        edge_push();
        e = sb.pop_front();
        vectors++;
        if (if_pc !== e.pc || if_en !== e.en || spm_addr !== 30'h3FFF_FFFF) begin
            errors++;
            $display("FAIL wrap_load: got pc=%h en=%b addr=%h want pc=%h en=%b addr=3fffffff",
                     if_pc, if_en, spm_addr, e.pc, e.en);
        end
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            edge_push();
            e = sb.pop_front();
            vectors++;
            if (if_pc !== e.pc || if_insn !== e.insn || if_en !== e.en) begin
                errors++;
                $display("FAIL wrap[%0d]: got pc=%h insn=%h en=%b want pc=%h insn=%h en=%b",
                         i, if_pc, if_insn, if_en, e.pc, e.insn, e.en);
            end
        end
        vectors++;
        if (if_pc !== 32'h4) begin
            errors++;
            $display("FAIL wrap_value: got pc=%h want pc=00000004", if_pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential();
        test_flush_branch();
        test_stall_priority();
        test_async_reset();
        test_wrap();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
